rf_multiport: RTL and testbench
===============================

// Module: rf_multiport
// PURPOSE
//  Parametrised next-generation register file for the multicycle datapath: N async read ports,
//  one byte-maskable write port, optional hard-wired zero register, optional write->read bypass.
//  Adds a sequential bulk-clear engine (on reset or on request) that zeroes one entry per cycle.
//  Sits between decode (read addresses) and write-back (write port), replacing the fixed 2R1W file.
// PARAMETERS
//  DATA_W    32  data width in bits; multiple of 8
//  ADDR_W    5   register address width
//  NUM_REGS  32  number of entries; 2 <= NUM_REGS <= 2**ADDR_W
//  NREAD     2   number of read ports, >= 1
//  ZERO_REG  1   1: entry 0 reads 0, writes to it are discarded
//  BYPASS    1   1: a read of the address written this cycle returns the merged new data
// PORTS
//  clk        in   1              clock; all state updates on posedge
//  rst        in   1              synchronous, active-high reset
//  clear_req  in   1              start bulk clear; sampled only in IDLE
//  busy       out  1              1 while the clear engine is running
//  RegWrite   in   1              write enable
//  WriteAddr  in   ADDR_W         write address
//  WriteData  in   DATA_W         write data
//  WriteBE    in   DATA_W/8       byte enables; bit i covers WriteData[8i+7:8i]
//  wr_drop    out  1              registered pulse: previous-cycle write discarded because busy
//  ReadAddr   in   NREAD*ADDR_W   port p address = ReadAddr[p*ADDR_W +: ADDR_W]
//  ReadData   out  NREAD*DATA_W   port p data    = ReadData[p*DATA_W +: DATA_W]
// BEHAVIOUR
//  - FSM states IDLE, CLEAR. Reset: state<=CLEAR, ptr<=0, wr_drop<=0; busy=1 next cycle.
//  - CLEAR: entry[ptr]<=0 each cycle, ptr++; at ptr==NUM_REGS-1 clear it and go IDLE.
//    Clear lasts exactly NUM_REGS cycles; busy is 1 for those cycles, then 0.
//  - rst asserted mid-CLEAR restarts the walk at ptr=0 (full NUM_REGS cycles again).
//  - IDLE & clear_req: go CLEAR, ptr<=0, same timing as reset. clear_req ignored while busy.
//  - Write (IDLE only): RegWrite & addr<NUM_REGS & !(ZERO_REG & addr==0) ->
//    per byte i with WriteBE[i]=1, entry[addr][byte i]<=WriteData[byte i]; other bytes kept.
//    WriteBE==0 is a legal no-op. Addr >= NUM_REGS: write ignored, no flag.
//  - RegWrite while busy: write discarded, wr_drop=1 on the following cycle only.
//  - IDLE & clear_req & RegWrite same cycle: clear wins, write discarded, wr_drop pulses.
//  - Read: combinational, zero-latency. busy=1 -> all ReadData=0.
//    addr>=NUM_REGS -> 0. ZERO_REG & addr==0 -> 0.
//  - BYPASS=1 and an accepted write targets the read address this cycle -> ReadData =
//    byte-merge(old entry, WriteData, WriteBE). BYPASS=0 -> old contents until the next edge.
//  - All read ports independent; any ports may share an address.
//  - Register contents undefined only before the first reset; no initial block is relied on.
// STRUCTURE
//  - Shared package rf_pkg: FSM state enum {RF_IDLE, RF_CLEAR}, helper function
//    be_merge(old, new, be) used by both write path and bypass.
//  - One sub-module rf_read_port (address decode, range/zero check, bypass mux), generated
//    NREAD times; storage, write logic and clear FSM live in rf_multiport.
// TESTING
//  1 rst 1 cycle -> busy=1 for exactly 32 cycles; afterwards all 32 entries read 0 on every port.
//  2 IDLE, write r5=0xDEADBEEF BE=4'hF, then r5=0x11223344 BE=4'b0101 -> r5 reads 0xDE22BE44.
//  3 BYPASS=1: write r7=0xCAFEF00D while ReadAddr port0=7 -> ReadData0=0xCAFEF00D same cycle;
//    BYPASS=0 -> old value same cycle, new value next cycle.
//  4 write r0=0xFFFFFFFF with ZERO_REG=1 -> r0 reads 0; ZERO_REG=0 -> r0 reads 0xFFFFFFFF.
//  5 clear_req at cycle t, rst again at t+10 -> busy stays 1 until t+10+32; RegWrite at t+3 ->
//    wr_drop=1 at t+4 only, target register reads 0 after clear.
//  6 NREAD=4, NUM_REGS=16: ports read 3,3,15,20 after writes r3=0xA, r15=0xB -> 0xA,0xA,0xB,0.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared definitions for the multiport register file.
//  - rf_state_e : clear-engine FSM states
//  - be_merge   : byte-enable merge, used by the write path and by the bypass path.
//                 It works on RF_MAX_W-bit vectors. Callers zero-extend their DATA_W
//                 operands and keep the low DATA_W bits of the result.
package rf_pkg;

  typedef enum logic [0:0] {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

  // Widest data word the merge helper supports.
  localparam int RF_MAX_W = 512;
  localparam int RF_MAX_B = RF_MAX_W / 8;

  // Byte i of the result comes from new_v when be[i] is set, otherwise from old_v.
  function automatic logic [RF_MAX_W-1:0] be_merge(
    input logic [RF_MAX_W-1:0] old_v,
    input logic [RF_MAX_W-1:0] new_v,
    input logic [RF_MAX_B-1:0] be
  );
    logic [RF_MAX_W-1:0] res;
    res = old_v;
    for (int i = 0; i < RF_MAX_B; i++) begin
      if (be[i]) res[i*8 +: 8] = new_v[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/rf_multiport_if.sv
// Bus between the datapath and rf_multiport.
//  clear_req  bulk-clear request       busy      clear engine running
//  RegWrite   write enable             WriteAddr write address
//  WriteData  write data               WriteBE   byte enables
//  wr_drop    previous write dropped   ReadAddr  packed read addresses (NREAD ports)
//  ReadData   packed read data (NREAD ports)
// master: the datapath side; slave: the register file.
interface rf_multiport_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 2
);
  logic                    clear_req;
  logic                    busy;
  logic                    RegWrite;
  logic [ADDR_W-1:0]       WriteAddr;
  logic [DATA_W-1:0]       WriteData;
  logic [DATA_W/8-1:0]     WriteBE;
  logic                    wr_drop;
  logic [NREAD*ADDR_W-1:0] ReadAddr;
  logic [NREAD*DATA_W-1:0] ReadData;

  modport master (
    output clear_req, RegWrite, WriteAddr, WriteData, WriteBE, ReadAddr,
    input  busy, wr_drop, ReadData
  );

  modport slave (
    input  clear_req, RegWrite, WriteAddr, WriteData, WriteBE, ReadAddr,
    output busy, wr_drop, ReadData
  );
endinterface

// File: rtl/rf_read_port.sv
// One combinational read port of rf_multiport.
//  mem_i        storage array (all entries)
//  rd_addr_i    read address
//  busy_i       clear engine running: output forced to zero
//  wr_accept_i  a write is being committed this cycle
//  wr_addr_i / wr_data_i / wr_be_i   the write being committed (for bypass)
//  rd_data_o    read data
// Out-of-range addresses and (with ZERO_REG) address 0 read as zero.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic [DATA_W-1:0]   mem_i [NUM_REGS],
  input  logic [ADDR_W-1:0]   rd_addr_i,
  input  logic                busy_i,
  input  logic                wr_accept_i,
  input  logic [ADDR_W-1:0]   wr_addr_i,
  input  logic [DATA_W-1:0]   wr_data_i,
  input  logic [DATA_W/8-1:0] wr_be_i,
  output logic [DATA_W-1:0]   rd_data_o
);

  localparam int IDX_W = $clog2(NUM_REGS);
  // One extra bit so the range compare never degenerates to a constant.
  localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);

  logic              in_range;
  logic              is_zero;
  logic              bypass_hit;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] stored;
  logic [DATA_W-1:0] merged;

  logic [RF_MAX_W-1:0] old_ext;
  logic [RF_MAX_W-1:0] new_ext;
  logic [RF_MAX_B-1:0] be_ext;
  logic [RF_MAX_W-1:0] merged_ext;
  logic                unused_merge_hi;

  assign in_range   = ({1'b0, rd_addr_i} < NUM_REGS_W);
  assign is_zero    = (ZERO_REG != 0) && (rd_addr_i == '0);
  assign idx        = rd_addr_i[IDX_W-1:0];
  assign stored     = in_range ? mem_i[idx] : '0;
  // wr_accept_i already excludes the zero register and out-of-range targets.
  assign bypass_hit = (BYPASS != 0) && wr_accept_i && (wr_addr_i == rd_addr_i);

  always_comb begin
    old_ext              = '0;
    new_ext              = '0;
    be_ext               = '0;
    old_ext[DATA_W-1:0]  = stored;
    new_ext[DATA_W-1:0]  = wr_data_i;
    be_ext[DATA_W/8-1:0] = wr_be_i;
    merged_ext           = be_merge(old_ext, new_ext, be_ext);
  end

  assign merged          = merged_ext[DATA_W-1:0];
  assign unused_merge_hi = ^merged_ext[RF_MAX_W-1:DATA_W];

  always_comb begin
    rd_data_o = '0;
    if (!busy_i && in_range && !is_zero) begin
      rd_data_o = bypass_hit ? merged : stored;
    end
  end

endmodule

// File: rtl/rf_multiport.sv
// Multiport register file: NREAD async read ports, one byte-maskable write port,
// optional hard-wired zero entry, optional write->read bypass, and a bulk-clear
// engine that zeroes one entry per cycle after reset or on clear_req.
//  clk   clock
//  rst   synchronous active-high reset (starts a full clear walk)
//  bus   rf_multiport_if.slave: write port, read ports, clear_req/busy, wr_drop
module rf_multiport
  import rf_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic           clk,
  input logic           rst,
  rf_multiport_if.slave bus
);

  localparam int                IDX_W      = $clog2(NUM_REGS);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_REGS - 1);
  localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);

  rf_state_e         state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic              wr_drop_q, wr_drop_d;
  logic [DATA_W-1:0] mem_q [NUM_REGS];

  logic              busy;
  logic              clr_we;
  logic              wr_in_range;
  logic              wr_is_zero;
  logic              wr_accept;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_merged;

  logic [RF_MAX_W-1:0] old_ext;
  logic [RF_MAX_W-1:0] new_ext;
  logic [RF_MAX_B-1:0] be_ext;
  logic [RF_MAX_W-1:0] merged_ext;
  logic                unused_merge_hi;

  logic [DATA_W-1:0] rd_data [NREAD];

  assign busy = (state_q == RF_CLEAR);

  // ---------------- clear engine ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RF_CLEAR;
      ptr_q     <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    clr_we    = 1'b0;
    wr_drop_d = 1'b0;
    case (state_q)
      RF_IDLE: begin
        // A clear request takes priority over a same-cycle write.
        if (bus.clear_req) begin
          state_d   = RF_CLEAR;
          ptr_d     = '0;
          wr_drop_d = bus.RegWrite;
        end
      end
      RF_CLEAR: begin
        clr_we    = 1'b1;
        wr_drop_d = bus.RegWrite;
        if (ptr_q == LAST_IDX) begin
          state_d = RF_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: begin
        state_d = RF_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  // ---------------- write path ----------------
  assign wr_in_range = ({1'b0, bus.WriteAddr} < NUM_REGS_W);
  assign wr_is_zero  = (ZERO_REG != 0) && (bus.WriteAddr == '0);
  assign wr_idx      = bus.WriteAddr[IDX_W-1:0];
  assign wr_accept   = bus.RegWrite && !busy && !bus.clear_req && !rst
                       && wr_in_range && !wr_is_zero;

  always_comb begin
    old_ext              = '0;
    new_ext              = '0;
    be_ext               = '0;
    old_ext[DATA_W-1:0]  = mem_q[wr_idx];
    new_ext[DATA_W-1:0]  = bus.WriteData;
    be_ext[DATA_W/8-1:0] = bus.WriteBE;
    merged_ext           = be_merge(old_ext, new_ext, be_ext);
  end

  assign wr_merged       = merged_ext[DATA_W-1:0];
  assign unused_merge_hi = ^merged_ext[RF_MAX_W-1:DATA_W];

  // Storage has no reset; contents become defined through the clear walk.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_we) begin
        mem_q[ptr_q] <= '0;
      end else if (wr_accept) begin
        mem_q[wr_idx] <= wr_merged;
      end
    end
  end

  // ---------------- read ports ----------------
  for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
    rf_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NUM_REGS (NUM_REGS),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_rd (
      .mem_i       (mem_q),
      .rd_addr_i   (bus.ReadAddr[gi*ADDR_W +: ADDR_W]),
      .busy_i      (busy),
      .wr_accept_i (wr_accept),
      .wr_addr_i   (bus.WriteAddr),
      .wr_data_i   (bus.WriteData),
      .wr_be_i     (bus.WriteBE),
      .rd_data_o   (rd_data[gi])
    );
  end

  always_comb begin
    bus.ReadData = '0;
    for (int p = 0; p < NREAD; p++) begin
      bus.ReadData[p*DATA_W +: DATA_W] = rd_data[p];
    end
  end

  assign bus.busy    = busy;
  assign bus.wr_drop = wr_drop_q;

endmodule

// File: tb/tb_rf_multiport.sv
// Bench for rf_multiport with two instances:
//  dut_a: 32 entries, 2 read ports, ZERO_REG=1, BYPASS=1
//  dut_b: 16 entries, 4 read ports, ZERO_REG=0, BYPASS=0
module tb_rf_multiport;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;

  rf_multiport_if #(.DATA_W(32), .ADDR_W(5), .NREAD(2)) ifa ();
  rf_multiport_if #(.DATA_W(32), .ADDR_W(5), .NREAD(4)) ifb ();

  rf_multiport #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .NREAD(2),
                 .ZERO_REG(1), .BYPASS(1)) dut_a (.clk(clk), .rst(rst_a), .bus(ifa));
  rf_multiport #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(16), .NREAD(4),
                 .ZERO_REG(0), .BYPASS(0)) dut_b (.clk(clk), .rst(rst_b), .bus(ifb));

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    string       tag;
    int          dut;
    int          port;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  wbe;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] exp0;
    logic [31:0] exp1;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] rd_val(input int dut, input int port);
    if (dut == 0) return ifa.ReadData[port*32 +: 32];
    return ifb.ReadData[port*32 +: 32];
  endfunction

  function automatic logic busy_of(input int dut);
    return (dut == 0) ? ifa.busy : ifb.busy;
  endfunction

  task automatic expect_rd(input string tag, input int dut, input int port, input logic [31:0] exp);
    sb_t e;
    e.tag = tag; e.dut = dut; e.port = port; e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    sb_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.tag, rd_val(e.dut, e.port), e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles with busy=1, starting from the current sample; bounded.
  task automatic count_busy(input int dut, output int n);
    n = 0;
    while (busy_of(dut) === 1'b1 && n < 200) begin
      n++;
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;

    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 4'hF,    5'd5,  5'd6,  32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b1, 5'd5,  32'h11223344, 4'b0101, 5'd5,  5'd5,  32'hDE22BE44, 32'hDE22BE44};
    vecs[2] = '{1'b0, 5'd0,  32'h0,        4'h0,    5'd5,  5'd0,  32'hDE22BE44, 32'h0};
    vecs[3] = '{1'b1, 5'd7,  32'hCAFEF00D, 4'hF,    5'd7,  5'd5,  32'hCAFEF00D, 32'hDE22BE44};
    vecs[4] = '{1'b1, 5'd0,  32'hFFFFFFFF, 4'hF,    5'd0,  5'd7,  32'h0,        32'hCAFEF00D};
    vecs[5] = '{1'b0, 5'd0,  32'h0,        4'h0,    5'd0,  5'd31, 32'h0,        32'h0};
    vecs[6] = '{1'b1, 5'd31, 32'h0000FFFF, 4'b0011, 5'd31, 5'd31, 32'h0000FFFF, 32'h0000FFFF};
    vecs[7] = '{1'b1, 5'd31, 32'hAABBCCDD, 4'b0000, 5'd31, 5'd5,  32'h0000FFFF, 32'hDE22BE44};
    vecs[8] = '{1'b1, 5'd31, 32'hAABBCCDD, 4'b1000, 5'd31, 5'd7,  32'hAA00FFFF, 32'hCAFEF00D};
    vecs[9] = '{1'b0, 5'd0,  32'h0,        4'h0,    5'd31, 5'd0,  32'hAA00FFFF, 32'h0};

    ifa.clear_req = 0; ifa.RegWrite = 0; ifa.WriteAddr = 0; ifa.WriteData = 0;
    ifa.WriteBE = 0; ifa.ReadAddr = 0;
    ifb.clear_req = 0; ifb.RegWrite = 0; ifb.WriteAddr = 0; ifb.WriteData = 0;
    ifb.WriteBE = 0; ifb.ReadAddr = 0;
    rst_a = 0; rst_b = 0;

    // ---------- reset of dut_b: 16-cycle clear ----------
    rst_b = 1; tick(); rst_b = 0;
    check("b_rst_wr_drop", 32'(ifb.wr_drop), 32'd0);
    count_busy(1, n);
    check("b_rst_busy_cycles", n, 16);
    $display("reset b: busy for %0d cycles", n);

    // ---------- reset of dut_a: 32-cycle clear ----------
    rst_a = 1; tick(); rst_a = 0;
    check("a_rst_busy", 32'(ifa.busy), 32'd1);
    check("a_rst_wr_drop", 32'(ifa.wr_drop), 32'd0);
    ifa.ReadAddr = {5'd9, 5'd5};
    #1;
    expect_rd("a_read_while_busy_p0", 0, 0, 32'h0);
    expect_rd("a_read_while_busy_p1", 0, 1, 32'h0);
    drain();
    count_busy(0, n);
    check("a_rst_busy_cycles", n, 32);
    $display("reset a: busy for %0d cycles", n);
    for (int i = 0; i < 32; i++) begin
      ifa.ReadAddr = {5'(i), 5'(31 - i)};
      #1;
      expect_rd("a_post_rst_zero_p0", 0, 0, 32'h0);
      expect_rd("a_post_rst_zero_p1", 0, 1, 32'h0);
      drain();
    end
    $display("sweep a: all entries checked for zero");

    // ---------- table-driven write/read vectors on dut_a ----------
    for (int i = 0; i < 10; i++) begin
      ifa.RegWrite  = vecs[i].we;
      ifa.WriteAddr = vecs[i].waddr;
      ifa.WriteData = vecs[i].wdata;
      ifa.WriteBE   = vecs[i].wbe;
      ifa.ReadAddr  = {vecs[i].ra1, vecs[i].ra0};
      expect_rd($sformatf("vec%0d_p0", i), 0, 0, vecs[i].exp0);
      expect_rd($sformatf("vec%0d_p1", i), 0, 1, vecs[i].exp1);
      #1;
      $display("vec %0d: we=%0b addr=%0d data=%h be=%h rd0=%h rd1=%h", i, vecs[i].we,
               vecs[i].waddr, vecs[i].wdata, vecs[i].wbe, rd_val(0, 0), rd_val(0, 1));
      drain();
      tick();
      check($sformatf("vec%0d_wr_drop", i), 32'(ifa.wr_drop), 32'd0);
    end
    ifa.RegWrite = 0;

    // ---------- clear_req, dropped write, reset mid-clear on dut_a ----------
    ifa.clear_req = 1;
    tick();                                   // edge t
    ifa.clear_req = 0;
    check("a_clr_busy_t", 32'(ifa.busy), 32'd1);
    tick(); tick();                           // edges t+1, t+2
    ifa.RegWrite = 1; ifa.WriteAddr = 5'd5; ifa.WriteData = 32'h12345678; ifa.WriteBE = 4'hF;
    ifa.ReadAddr = {5'd7, 5'd5};
    #1;
    expect_rd("a_clr_read_p0", 0, 0, 32'h0);
    expect_rd("a_clr_read_p1", 0, 1, 32'h0);
    drain();
    tick();                                   // edge t+3
    ifa.RegWrite = 0;
    check("a_wr_drop_pulse", 32'(ifa.wr_drop), 32'd1);
    tick();                                   // edge t+4
    check("a_wr_drop_clear", 32'(ifa.wr_drop), 32'd0);
    for (int i = 0; i < 5; i++) tick();       // edges t+5 .. t+9
    check("a_busy_before_rst", 32'(ifa.busy), 32'd1);
    rst_a = 1;
    tick();                                   // edge t+10
    rst_a = 0;
    count_busy(0, n);
    check("a_restart_busy_cycles", n, 32);
    $display("clear a: reset mid-clear, busy for %0d more cycles", n);
    ifa.ReadAddr = {5'd7, 5'd5};
    #1;
    expect_rd("a_after_clr_r5", 0, 0, 32'h0);
    expect_rd("a_after_clr_r7", 0, 1, 32'h0);
    drain();
    ifa.ReadAddr = {5'd31, 5'd0};
    #1;
    expect_rd("a_after_clr_r0", 0, 0, 32'h0);
    expect_rd("a_after_clr_r31", 0, 1, 32'h0);
    drain();

    // ---------- dut_b: no bypass, no zero register, 4 ports, 16 entries ----------
    ifb.RegWrite = 1; ifb.WriteAddr = 5'd3; ifb.WriteData = 32'hA; ifb.WriteBE = 4'hF;
    ifb.ReadAddr = {5'd20, 5'd15, 5'd3, 5'd3};
    #1;
    expect_rd("b_w3_same_p0", 1, 0, 32'h0);
    expect_rd("b_w3_same_p1", 1, 1, 32'h0);
    expect_rd("b_w3_same_p2", 1, 2, 32'h0);
    expect_rd("b_w3_same_p3", 1, 3, 32'h0);
    drain();
    $display("b: write r3=%h, same-cycle reads checked", 32'hA);
    tick();
    ifb.WriteAddr = 5'd15; ifb.WriteData = 32'hB;
    #1;
    expect_rd("b_w15_p0", 1, 0, 32'hA);
    expect_rd("b_w15_p1", 1, 1, 32'hA);
    expect_rd("b_w15_old_p2", 1, 2, 32'h0);
    expect_rd("b_w15_p3", 1, 3, 32'h0);
    drain();
    $display("b: write r15=%h, old value on same cycle", 32'hB);
    tick();
    ifb.WriteAddr = 5'd0; ifb.WriteData = 32'hFFFFFFFF;
    ifb.ReadAddr = {5'd20, 5'd15, 5'd3, 5'd0};
    #1;
    expect_rd("b_w0_old_p0", 1, 0, 32'h0);
    expect_rd("b_w0_p1", 1, 1, 32'hA);
    expect_rd("b_r15_p2", 1, 2, 32'hB);
    expect_rd("b_r20_p3", 1, 3, 32'h0);
    drain();
    $display("b: write r0=%h", 32'hFFFFFFFF);
    tick();
    ifb.WriteAddr = 5'd20; ifb.WriteData = 32'h55;
    ifb.ReadAddr = {5'd20, 5'd4, 5'd0, 5'd3};
    #1;
    expect_rd("b_r3_p0", 1, 0, 32'hA);
    expect_rd("b_r0_nozero_p1", 1, 1, 32'hFFFFFFFF);
    expect_rd("b_r4_p2", 1, 2, 32'h0);
    expect_rd("b_r20_oor_p3", 1, 3, 32'h0);
    drain();
    $display("b: write to out-of-range address 20");
    tick();
    ifb.RegWrite = 0;
    check("b_oor_no_drop", 32'(ifb.wr_drop), 32'd0);
    #1;
    expect_rd("b_r4_no_alias", 1, 2, 32'h0);
    expect_rd("b_r20_after", 1, 3, 32'h0);
    drain();

    // clear_req and RegWrite together in IDLE: clear wins
    ifb.clear_req = 1; ifb.RegWrite = 1; ifb.WriteAddr = 5'd3; ifb.WriteData = 32'h77;
    #1;
    expect_rd("b_clr_same_cycle_r3", 1, 0, 32'hA);
    drain();
    tick();
    ifb.clear_req = 0; ifb.RegWrite = 0;
    check("b_clr_wr_drop", 32'(ifb.wr_drop), 32'd1);
    check("b_clr_busy", 32'(ifb.busy), 32'd1);
    tick();
    check("b_clr_wr_drop_once", 32'(ifb.wr_drop), 32'd0);
    // a clear_req pulse while busy must not extend the walk
    n = 1;
    while (ifb.busy === 1'b1 && n < 200) begin
      n++;
      ifb.clear_req = (n == 5);
      tick();
    end
    ifb.clear_req = 0;
    check("b_clr_busy_cycles", n, 16);
    $display("b: clear with same-cycle write, busy for %0d cycles", n);
    ifb.ReadAddr = {5'd4, 5'd0, 5'd15, 5'd3};
    #1;
    expect_rd("b_after_clr_r3", 1, 0, 32'h0);
    expect_rd("b_after_clr_r15", 1, 1, 32'h0);
    expect_rd("b_after_clr_r0", 1, 2, 32'h0);
    expect_rd("b_after_clr_r4", 1, 3, 32'h0);
    drain();
    tick();
    check("b_idle_after_clr", 32'(ifb.busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
